// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte transmitter between NumReq requesters,
// holding each grantee until its last byte, with an optional idle gap between packets.
module uart_tx_scheduler #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataBits  = 8,
  parameter int unsigned GapCycles = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NumReq-1:0]            req_valid,
  input  logic [NumReq*DataBits-1:0]   req_data,
  input  logic [NumReq-1:0]            req_last,
  output logic [NumReq-1:0]            req_ready,
  output logic [DataBits-1:0]          tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NumReq)-1:0]    grant_idx,
  output logic                         pkt_active
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam logic [15:0] GapLoad = 16'((GapCycles > 0) ? GapCycles - 1 : 0);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    LOCK,
    GAP
  } state_e;

  state_e                state_q;
  logic [DataBits-1:0]   tx_data_q;
  logic                  tx_valid_q;
  logic [IdxW-1:0]       grant_q;
  logic [IdxW-1:0]       last_grant_q;
  logic                  pkt_active_q;
  logic                  guard_q;
  logic [15:0]           gap_cnt_q;

  logic [IdxW-1:0]       win_d;
  logic                  win_found_d;
  logic [NumReq-1:0]     ready_d;
  logic                  accept_d;
  logic [IdxW-1:0]       acc_idx_d;
  logic [DataBits-1:0]   acc_data_d;
  logic                  acc_last_d;

  // Round-robin search starting just after the previous grantee, with wrap.
  always_comb begin
    int unsigned cand;
    win_d       = '0;
    win_found_d = 1'b0;
    cand        = 0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!win_found_d && req_valid[cand]) begin
        win_d       = IdxW'(cand);
        win_found_d = 1'b1;
      end
    end
  end

  always_comb begin
    ready_d = '0;
    if (rst_n) begin
      case (state_q)
        IDLE:    if (tx_ready && win_found_d) ready_d[win_d] = 1'b1;
        LOCK:    if (tx_ready && req_valid[grant_q]) ready_d[grant_q] = 1'b1;
        default: ready_d = '0;
      endcase
    end
  end

  always_comb begin
    accept_d   = |ready_d;
    acc_idx_d  = (state_q == LOCK) ? grant_q : win_d;
    acc_data_d = req_data[acc_idx_d*DataBits +: DataBits];
    acc_last_d = req_last[acc_idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      pkt_active_q <= 1'b0;
      guard_q      <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      case (state_q)
        IDLE, LOCK: begin
          if (accept_d) begin
            tx_data_q    <= acc_data_d;
            tx_valid_q   <= 1'b1;
            grant_q      <= acc_idx_d;
            pkt_active_q <= ~acc_last_d;
            if (state_q == IDLE) last_grant_q <= acc_idx_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          guard_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          // First WAIT cycle masks the transmitter's ready fall after the load.
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (tx_ready) begin
            if (pkt_active_q) begin
              state_q <= LOCK;
            end else if (GapCycles > 0) begin
              gap_cnt_q <= GapLoad;
              state_q   <= GAP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q <= IDLE;
          else                 gap_cnt_q <= gap_cnt_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_d;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign grant_idx  = grant_q;
  assign pkt_active = pkt_active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance without gap, one with GapCycles=5.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [1:0]  grant_idx;
  logic        pkt_active;

  logic [3:0]  g_valid, g_last, g_ready;
  logic [31:0] g_data;
  logic [7:0]  g_txd;
  logic        g_txv, g_txr;
  logic [1:0]  g_grant;
  logic        g_active;

  uart_tx_scheduler #(.NumReq(4), .DataBits(8), .GapCycles(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_idx(grant_idx), .pkt_active(pkt_active)
  );

  uart_tx_scheduler #(.NumReq(4), .DataBits(8), .GapCycles(5)) u_gap (
    .clk(clk), .rst_n(rst_n),
    .req_valid(g_valid), .req_data(g_data), .req_last(g_last), .req_ready(g_ready),
    .tx_data(g_txd), .tx_valid(g_txv), .tx_ready(g_txr),
    .grant_idx(g_grant), .pkt_active(g_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester byte sources: {last, data}
  logic [8:0]  src_mem [4][8];
  int          src_len [4];
  int          src_ptr [4];

  logic [7:0]  log_data [$];
  logic [1:0]  log_grant [$];

  int          frame = 0;
  int          busy = 0;
  logic        prev_txv = 1'b0;
  int          viol = 0;
  int          lock_viol = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_mem[i][src_ptr[i]][7:0];
        req_last[i]        = src_mem[i][src_ptr[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
  endtask

  task automatic push_src(input int i, input logic last, input logic [7:0] d);
    src_mem[i][src_len[i]] = {last, d};
    src_len[i]++;
  endtask

  // One clock: consume handshaken bytes, log loads, model transmitter busy time.
  task automatic tick();
    logic [3:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (hs[i]) src_ptr[i]++;
    if (tx_valid) begin
      log_data.push_back(tx_data);
      log_grant.push_back(grant_idx);
      if (prev_txv) viol++;
      busy = frame;
    end else if (busy > 0) begin
      busy--;
    end
    prev_txv = tx_valid;
    tx_ready = (busy == 0);
    drive_srcs();
    #1;
    if ($countones(req_ready) > 1) viol++;
    if (pkt_active && ((req_ready & ~(4'b0001 << grant_idx)) != 4'b0000)) lock_viol++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_srcs();
    drive_srcs();
    busy = 0;
    tx_ready = 1'b1;
    prev_txv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] exp_rr [5];
    logic [1:0] exp_rg [5];

    exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_rg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    clear_srcs();
    drive_srcs();
    tx_ready = 1'b1;
    g_valid = '0; g_last = '0; g_data = '0; g_txr = 1'b1;

    // Reset state, with a request pending during reset
    @(negedge clk);
    push_src(0, 1'b1, 8'hEE);
    drive_srcs();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_txd", 32'(tx_data), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    chk("rst_active", 32'(pkt_active), 32'h0);
    do_reset();

    // Single byte
    push_src(0, 1'b1, 8'hA5);
    drive_srcs();
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_active0", 32'(pkt_active), 32'h0);
    tick();
    chk("single_txv", 32'(tx_valid), 32'h1);
    chk("single_txd", 32'(tx_data), 32'hA5);
    chk("single_active1", 32'(pkt_active), 32'h0);
    tick();
    chk("single_txv_once", 32'(tx_valid), 32'h0);
    repeat (3) tick();
    chk("single_active2", 32'(pkt_active), 32'h0);

    // Round robin from a fresh pointer
    do_reset();
    log_data.delete(); log_grant.delete();
    push_src(0, 1'b1, 8'h10); push_src(0, 1'b1, 8'h10);
    push_src(1, 1'b1, 8'h11);
    push_src(2, 1'b1, 8'h12);
    push_src(3, 1'b1, 8'h13);
    drive_srcs();
    #1;
    repeat (30) tick();
    chk("rr_count", 32'(log_data.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_data%0d", k), 32'(log_data[k]), 32'(exp_rr[k]));
      chk($sformatf("rr_grant%0d", k), 32'(log_grant[k]), 32'(exp_rg[k]));
    end

    // Packet lock with a slow transmitter; pointer at 0 so req1 wins over req2
    frame = 3;
    log_data.delete(); log_grant.delete();
    push_src(1, 1'b0, 8'h11); push_src(1, 1'b0, 8'h22); push_src(1, 1'b1, 8'h33);
    push_src(2, 1'b1, 8'h44);
    drive_srcs();
    #1;
    n = 0;
    while (log_data.size() < 4 && n < 80) begin tick(); n++; end
    chk("lock_count", 32'(log_data.size()), 32'd4);
    chk("lock_b0", 32'(log_data[0]), 32'h11);
    chk("lock_b1", 32'(log_data[1]), 32'h22);
    chk("lock_b2", 32'(log_data[2]), 32'h33);
    chk("lock_b3", 32'(log_data[3]), 32'h44);
    chk("lock_g3", 32'(log_grant[3]), 32'd2);
    repeat (10) tick();

    // Starved lock: req3 (next after 2) wins, then goes silent while req0 waits
    frame = 0;
    log_data.delete(); log_grant.delete();
    push_src(3, 1'b0, 8'h55);
    push_src(0, 1'b1, 8'h77);
    drive_srcs();
    #1;
    n = 0;
    while (src_ptr[3] < 1 && n < 20) begin tick(); n++; end
    chk("starve_accepted", 32'(src_ptr[3]), 32'd1);
    repeat (50) tick();
    chk("starve_pulses", 32'(log_data.size()), 32'd1);
    chk("starve_active", 32'(pkt_active), 32'h1);
    chk("starve_grant", 32'(grant_idx), 32'd3);
    chk("starve_ready", 32'(req_ready), 32'h0);
    push_src(3, 1'b1, 8'h66);
    drive_srcs();
    #1;
    chk("starve_resume", 32'(req_ready), 32'h8);
    n = 0;
    while (log_data.size() < 3 && n < 30) begin tick(); n++; end
    chk("starve_b1", 32'(log_data[1]), 32'h66);
    chk("starve_b2", 32'(log_data[2]), 32'h77);
    chk("starve_g2", 32'(log_grant[2]), 32'd0);
    repeat (6) tick();

    // Reset during WAIT of a locked packet from req1
    log_data.delete(); log_grant.delete();
    push_src(1, 1'b0, 8'h91); push_src(1, 1'b1, 8'h92);
    drive_srcs();
    #1;
    n = 0;
    while (log_data.size() < 1 && n < 20) begin tick(); n++; end
    tick();
    chk("mid_active", 32'(pkt_active), 32'h1);
    chk("mid_grant", 32'(grant_idx), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", 32'(pkt_active), 32'h0);
    chk("mid_rst_txv", 32'(tx_valid), 32'h0);
    chk("mid_rst_grant", 32'(grant_idx), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    clear_srcs();
    push_src(0, 1'b1, 8'hA0);
    push_src(2, 1'b1, 8'hC2);
    drive_srcs();
    busy = 0; tx_ready = 1'b1; prev_txv = 1'b0;
    log_data.delete(); log_grant.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n = 0;
    while (log_data.size() < 2 && n < 30) begin tick(); n++; end
    chk("post_rst_b0", 32'(log_data[0]), 32'hA0);
    chk("post_rst_g0", 32'(log_grant[0]), 32'd0);
    chk("post_rst_b1", 32'(log_data[1]), 32'hC2);

    // Gap: two single-byte packets, ideal transmitter, GapCycles=5
    @(negedge clk);
    g_valid = 4'b0011; g_last = 4'b0011; g_data = 32'h0000_0201; g_txr = 1'b1;
    #1;
    chk("gap_first", 32'(g_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    g_valid[0] = 1'b0;
    #1;
    chk("gap_txv", 32'(g_txv), 32'h1);
    chk("gap_txd", 32'(g_txd), 32'h01);
    n = 1;
    while (g_ready == 4'b0000 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n++;
    end
    chk("gap_spacing", 32'(n), 32'd9);
    chk("gap_next", 32'(g_ready), 32'h2);
    @(negedge clk);
    g_valid = '0;

    chk("no_double_or_multi", 32'(viol), 32'd0);
    chk("lock_isolation", 32'(lock_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one serial transmitter between NumReq byte-stream requesters.
- Each requester offers bytes with a `last` marker. A granted requester keeps the transmitter until its `last` byte is accepted (packet lock), so packets are never interleaved on the line.
- Arbitration between packets is round-robin.
- An optional idle gap can be inserted between packets.
- Sits between software-visible TX queues and the transmitter's data/valid/ready port.

Parameters:
- NumReq, 4, number of requesters; legal range [2,8].
- DataBits, 8, byte width; must match the transmitter.
- GapCycles, 0, idle clock cycles inserted after each packet's final byte completes, before re-arbitration; legal range [0,65535].

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NumReq  requester i has a byte available.
- req_data  input  NumReq*DataBits  byte of requester i at [i*DataBits +: DataBits].
- req_last  input  NumReq  byte of requester i ends its packet.
- req_ready  output  NumReq  one-hot accept pulse; byte i is consumed in the cycle req_valid[i] && req_ready[i].
- tx_data  output  DataBits  byte to the transmitter.
- tx_valid  output  1  single-cycle load pulse to the transmitter.
- tx_ready  input  1  transmitter idle and able to load.
- grant_idx  output  $clog2(NumReq)  current or most recent grantee.
- pkt_active  output  1  a packet lock is held.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; tx_valid=0; tx_data=0; grant_idx=0; pkt_active=0.
  - RR pointer last_grant=NumReq-1, so requester 0 has first priority.
  - req_ready is forced to all-zero while rst_n is low.
  - Reset mid-packet drops the lock and any captured byte. No partial pulse is emitted after reset deasserts.
- States: IDLE, ISSUE, WAIT, LOCK, GAP.
- IDLE:
  - If tx_ready && |req_valid: pick winner w as the first set req_valid bit searching from (last_grant+1) mod NumReq upward with wrap.
  - In the same cycle: req_ready[w]=1; capture req_data[w] into tx_data; grant_idx<=w; last_grant<=w; pkt_active<=~req_last[w]; go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE:
  - tx_valid=1 for exactly this cycle; tx_data is stable.
  - Next state is WAIT unconditionally.
- WAIT:
  - The tx_ready value in the first WAIT cycle is ignored, covering the transmitter's ready fall after the load.
  - From the second WAIT cycle on, when tx_ready=1:
    - pkt_active=1 -> LOCK.
    - else GapCycles>0 -> GAP.
    - else -> IDLE.
- LOCK:
  - Only requester grant_idx is served. Other requesters see req_ready=0 regardless of their valid.
  - If req_valid[grant_idx] (tx_ready known high): accept and capture as in IDLE, without updating last_grant; pkt_active<=~req_last[grant_idx]; go to ISSUE.
  - The lock is held indefinitely while the grantee is starved; there is no timeout.
- GAP:
  - Down-counter loaded with GapCycles-1 on entry; decrements each cycle; exit to IDLE when it reaches 0.
  - Exactly GapCycles cycles are spent in GAP.
  - Requests arriving during GAP wait; none are accepted.
- Throughput: at most one byte per transmitter frame.
  - Overhead per byte is the capture cycle plus the ISSUE cycle plus the WAIT guard.
  - Back-to-back bytes of one packet have no gap cycles.
- req_ready is combinational from state, req_valid, tx_ready and grant_idx. It is at most one-hot and never asserted outside IDLE/LOCK.
- tx_valid is never high on two consecutive cycles, and never high unless tx_ready was high in the preceding capture cycle.
- A single-byte packet (req_last=1 on the first byte) sets pkt_active=0 and behaves as a complete packet.
- Simultaneous requests from all requesters are served in pointer order: 0, 1, 2, … NumReq-1, 0, …
- Requester rules: req_data and req_last must be stable while req_valid is high and unaccepted. Dropping req_valid before acceptance is legal.

Test Plan:
- Single byte: NumReq=4; req0 sends 8'hA5 with last=1 while tx_ready=1 -> req_ready[0] pulses in cycle t; tx_valid=1 with tx_data=8'hA5 at t+1; pkt_active=0 throughout; return to IDLE.
- Round-robin: all four requesters hold single-byte packets 8'h10..8'h13 with an ideal transmitter -> tx_data sequence 10,11,12,13,10; grant_idx 0,1,2,3,0.
- Packet lock: req1 sends 3 bytes (11,22,33; last on 33) while req2 is continuously valid -> all three req1 bytes go out before any req2 byte; req_ready[2] stays 0 while pkt_active=1.
- Gap: GapCycles=5; two single-byte packets back-to-back -> exactly 5 GAP cycles between the first tx_ready return and the next req_ready pulse.
- Starved lock: req3 sends a first byte with last=0, then deasserts valid for 50 cycles while req0 is valid -> no tx_valid pulses; pkt_active=1; req3's next byte is accepted immediately on its return.
- Reset mid-packet: assert rst_n=0 during WAIT of a locked packet -> tx_valid=0 and pkt_active=0 immediately; after release, req0 wins first (pointer reset).
